bf_run_coalescer: RTL and testbench

Front-end stage that consumes the Brainfuck command byte stream and collapses runs of `+`/`-` and `>`/`<` into single signed operations for the 16-bit adder/subtractor datapath, which sits directly downstream. Each emitted run op drives the adder's `b` operand with a magnitude and its `sub` control with a direction. Control-flow and I/O commands pass through unchanged. Comment bytes are discarded.

---
 rtl/bf_pkg.sv | 34 +++
 rtl/bf_cmd_classify.sv | 27 ++
 rtl/bf_run_coalescer.sv | 139 +++++++++++++
 tb/tb_bf_run_coalescer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// bf_pkg: shared types and ASCII command constants for the Brainfuck front-end.
`default_nettype none

package bf_pkg;

   typedef enum logic [1:0] {
      OP_CELL = 2'd0,
      OP_PTR  = 2'd1,
      OP_PASS = 2'd2
   } op_kind_t;

   typedef enum logic [1:0] {
      CLS_CELL    = 2'd0,
      CLS_PTR     = 2'd1,
      CLS_PASS    = 2'd2,
      CLS_COMMENT = 2'd3
   } cmd_class_t;

   localparam logic [7:0] CH_INC        = 8'h2B;  // +
   localparam logic [7:0] CH_DEC        = 8'h2D;  // -
   localparam logic [7:0] CH_RIGHT      = 8'h3E;  // >
   localparam logic [7:0] CH_LEFT       = 8'h3C;  // <
   localparam logic [7:0] CH_LOOP_OPEN  = 8'h5B;  // [
   localparam logic [7:0] CH_LOOP_CLOSE = 8'h5D;  // ]
   localparam logic [7:0] CH_OUT        = 8'h2E;  // .
   localparam logic [7:0] CH_IN         = 8'h2C;  // ,

   function automatic op_kind_t run_kind_of(input cmd_class_t cls);
      return (cls == CLS_PTR) ? OP_PTR : OP_CELL;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bf_cmd_classify.sv
// bf_cmd_classify: maps a command byte to its class and direction (neg=1 for '-' and '<').
`default_nettype none

module bf_cmd_classify
   import bf_pkg::*;
(
   input  logic [7:0] data,
   output cmd_class_t cls,
   output logic       neg
);

   always_comb begin
      cls = CLS_COMMENT;
      neg = 1'b0;
      case (data)
         CH_INC:   cls = CLS_CELL;
         CH_DEC:   begin cls = CLS_CELL; neg = 1'b1; end
         CH_RIGHT: cls = CLS_PTR;
         CH_LEFT:  begin cls = CLS_PTR;  neg = 1'b1; end
         CH_LOOP_OPEN, CH_LOOP_CLOSE, CH_OUT, CH_IN: cls = CLS_PASS;
         default:  ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/bf_run_coalescer.sv
// bf_run_coalescer: collapses +/- and >/< runs into signed magnitude ops; other commands pass through.
// Optional BF_ZERO_DROP_EN: runs that net to zero are dropped instead of emitted.
`default_nettype none

module bf_run_coalescer
   import bf_pkg::*;
#(
   parameter int              DW      = 16,
   parameter logic [DW-1:0]   MAX_RUN = 16'hFFFF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_data,
   input  logic          flush,
   output logic          op_valid,
   input  logic          op_ready,
   output op_kind_t      op_kind,
   output logic [DW-1:0] op_mag,
   output logic          op_sub,
   output logic [7:0]    op_cmd
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ACC       = 2'd1;
   localparam logic [1:0] S_EMIT_RUN  = 2'd2;
   localparam logic [1:0] S_EMIT_PASS = 2'd3;

   localparam logic [DW-1:0] MAG_ONE = {{(DW-1){1'b0}}, 1'b1};

`ifdef BF_ZERO_DROP_EN
   localparam bit ZERO_DROP = 1'b1;
`else
   localparam bit ZERO_DROP = 1'b0;
`endif

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic signed [DW:0] net;
   logic signed [DW:0] net_step;
   logic signed [DW:0] net_upd;
   logic [DW-1:0]    mag_upd;
   op_kind_t         run_kind;
   cmd_class_t       cls;
   logic             neg;
   logic             is_run;
   logic             same_cls;
   logic             accept;
   logic             step_en;
   logic             sat;

   bf_cmd_classify u_classify (
      .data (cmd_data),
      .cls  (cls),
      .neg  (neg)
   );

   assign is_run   = (cls == CLS_CELL) || (cls == CLS_PTR);
   assign same_cls = is_run && (run_kind_of(cls) == run_kind);
   assign accept   = cmd_valid && cmd_ready;
   assign step_en  = accept && (((state == S_IDLE) && is_run) || ((state == S_ACC) && same_cls));
   assign net_step = neg ? '1 : {{DW{1'b0}}, 1'b1};
   assign net_upd  = step_en ? (net + net_step) : net;
   // |net| never exceeds MAX_RUN, so the low DW bits of the negation are the magnitude.
   assign mag_upd  = net_upd[DW] ? (~net_upd[DW-1:0] + MAG_ONE) : net_upd[DW-1:0];
   assign sat      = step_en && (mag_upd == MAX_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (is_run)                state_nxt = sat ? S_EMIT_RUN : S_ACC;
               else if (cls == CLS_PASS)  state_nxt = S_EMIT_PASS;
            end
         end
         S_ACC: begin
            if (sat)
               state_nxt = S_EMIT_RUN;
            else if (flush || (cmd_valid && !cmd_ready))
               state_nxt = (ZERO_DROP && (net == '0)) ? S_IDLE : S_EMIT_RUN;
         end
         S_EMIT_RUN, S_EMIT_PASS: begin
            if (op_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      case (state)
         S_IDLE:  cmd_ready = 1'b1;
         S_ACC:   cmd_ready = !flush && (same_cls || (cls == CLS_COMMENT));
         default: cmd_ready = 1'b0;
      endcase
   end

   // Op fields load only on entry to an emit state so they hold steady under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         net      <= '0;
         run_kind <= OP_CELL;
         op_valid <= 1'b0;
         op_kind  <= OP_CELL;
         op_mag   <= '0;
         op_sub   <= 1'b0;
         op_cmd   <= '0;
      end else begin
         op_valid <= (state_nxt == S_EMIT_RUN) || (state_nxt == S_EMIT_PASS);
         if ((state == S_IDLE) && accept && is_run)
            run_kind <= run_kind_of(cls);
         if ((state == S_EMIT_RUN) && op_ready)
            net <= '0;
         else
            net <= net_upd;
         if ((state != S_EMIT_RUN) && (state_nxt == S_EMIT_RUN)) begin
            op_kind <= (state == S_IDLE) ? run_kind_of(cls) : run_kind;
            op_mag  <= mag_upd;
            op_sub  <= net_upd[DW];
            op_cmd  <= '0;
         end else if ((state != S_EMIT_PASS) && (state_nxt == S_EMIT_PASS)) begin
            op_kind <= OP_PASS;
            op_mag  <= '0;
            op_sub  <= 1'b0;
            op_cmd  <= cmd_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bf_run_coalescer.sv
// tb_bf_run_coalescer: directed stimulus with a scoreboard queue checked by an output monitor.
`timescale 1ns/1ps
`default_nettype none

module tb_bf_run_coalescer;
   import bf_pkg::*;

   localparam int DW = 16;

   typedef struct packed {
      op_kind_t      kind;
      logic [DW-1:0] mag;
      logic          sub;
      logic [7:0]    cmd;
   } op_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   logic cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic flush = 1'b0;
   logic op_ready = 1'b1;

   always #5 clk = ~clk;

   logic          cmd_ready_a, cmd_ready_b, op_valid_a, op_valid_b;
   op_kind_t      op_kind_a, op_kind_b;
   logic [DW-1:0] op_mag_a, op_mag_b;
   logic          op_sub_a, op_sub_b;
   logic [7:0]    op_cmd_a, op_cmd_b;

   // Instance a: default MAX_RUN; instance b: MAX_RUN=4. sel routes stimulus and observation.
   bf_run_coalescer #(.DW(DW), .MAX_RUN(16'hFFFF)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready_a), .cmd_data(cmd_data),
      .flush(flush & ~sel),
      .op_valid(op_valid_a), .op_ready(op_ready), .op_kind(op_kind_a),
      .op_mag(op_mag_a), .op_sub(op_sub_a), .op_cmd(op_cmd_a)
   );

   bf_run_coalescer #(.DW(DW), .MAX_RUN(16'd4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready_b), .cmd_data(cmd_data),
      .flush(flush & sel),
      .op_valid(op_valid_b), .op_ready(op_ready), .op_kind(op_kind_b),
      .op_mag(op_mag_b), .op_sub(op_sub_b), .op_cmd(op_cmd_b)
   );

   logic          cmd_ready, op_valid, op_sub;
   op_kind_t      op_kind;
   logic [DW-1:0] op_mag;
   logic [7:0]    op_cmd;
   op_t           cur;

   assign cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
   assign op_valid  = sel ? op_valid_b  : op_valid_a;
   assign op_kind   = sel ? op_kind_b   : op_kind_a;
   assign op_mag    = sel ? op_mag_b    : op_mag_a;
   assign op_sub    = sel ? op_sub_b    : op_sub_a;
   assign op_cmd    = sel ? op_cmd_b    : op_cmd_a;
   assign cur       = {op_kind, op_mag, op_sub, op_cmd};

   op_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  stall_cnt = 0;
   logic prev_stall = 1'b0;
   op_t  prev_op;

   task automatic expect_op(input op_kind_t k, input int m, input logic s, input logic [7:0] c);
      op_t e;
      e.kind = k; e.mag = DW'(m); e.sub = s; e.cmd = c;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: pops on every handshake and checks that a stalled op holds its fields.
   always @(negedge clk) begin
      op_t e;
      if (rst_n) begin
         if (prev_stall && op_valid) begin
            tests++;
            if (cur !== prev_op) begin
               fails++;
               $display("FAIL op_hold: got kind=%0d mag=%0d sub=%0b cmd=%02h, required kind=%0d mag=%0d sub=%0b cmd=%02h",
                        cur.kind, cur.mag, cur.sub, cur.cmd, prev_op.kind, prev_op.mag, prev_op.sub, prev_op.cmd);
            end
         end
         if (op_valid && !op_ready) stall_cnt++;
         if (op_valid && op_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL op_unexpected: got kind=%0d mag=%0d sub=%0b cmd=%02h, required no op",
                        cur.kind, cur.mag, cur.sub, cur.cmd);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  fails++;
                  $display("FAIL op_compare: got kind=%0d mag=%0d sub=%0b cmd=%02h, required kind=%0d mag=%0d sub=%0b cmd=%02h",
                           cur.kind, cur.mag, cur.sub, cur.cmd, e.kind, e.mag, e.sub, e.cmd);
               end
            end
         end
         prev_stall = op_valid && !op_ready;
         prev_op    = cur;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Offer a byte until consumed; waited counts cycles it was refused.
   task automatic send(input logic [7:0] b, output int waited);
      logic rdy;
      bit   done;
      waited = 0;
      done = 1'b0;
      cmd_valid = 1'b1;
      cmd_data  = b;
      while (!done) begin
         @(negedge clk);
         rdy = cmd_ready;
         @(posedge clk); #1;
         if (rdy) done = 1'b1;
         else begin
            waited++;
            if (waited > 200) begin
               tests++; fails++;
               $display("FAIL send_timeout: byte %02h got no cmd_ready, required consumption within 200 cycles", b);
               done = 1'b1;
            end
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic put(input logic [7:0] b);
      int w;
      send(b, w);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); n++;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!op_valid && n < 50);
      if (!op_valid) begin
         tests++; fails++;
         $display("FAIL %s: got op_valid=0 after 50 cycles, required 1", name);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      repeat (2) @(posedge clk);
      #1;
      check("rst_op_valid", op_valid, 0);
      check("rst_op_kind",  op_kind, OP_CELL);
      check("rst_op_mag",   op_mag, 0);
      check("rst_op_sub",   op_sub, 0);
      check("rst_op_cmd",   op_cmd, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;

      // + + + > : CELL 3, '>' refused for two cycles
      expect_op(OP_CELL, 3, 1'b0, 8'h00);
      put(CH_INC); put(CH_INC); put(CH_INC);
      send(CH_RIGHT, w);
      check("gt_consume_delay", w, 2);
      expect_op(OP_PTR, 1, 1'b0, 8'h00);
      do_flush();

      // < x5 then + : PTR 5 negative, then a CELL run
      expect_op(OP_PTR, 5, 1'b1, 8'h00);
      expect_op(OP_CELL, 1, 1'b0, 8'h00);
      repeat (5) put(CH_LEFT);
      put(CH_INC);
      do_flush();

      // + x - - flush : comment dropped, CELL 1 negative
      expect_op(OP_CELL, 1, 1'b1, 8'h00);
      put(CH_INC); put("x"); put(CH_DEC); put(CH_DEC);
      do_flush();
      drain();

      // + [ with backpressure for 4 cycles
      expect_op(OP_CELL, 1, 1'b0, 8'h00);
      expect_op(OP_PASS, 0, 1'b0, 8'h5B);
      op_ready = 1'b0;
      put(CH_INC);
      stall_cnt = 0;
      fork
         send(CH_LOOP_OPEN, w);
         begin
            wait_valid("stall_valid");
            repeat (3) @(negedge clk);
            @(posedge clk); #1;
            op_ready = 1'b1;
         end
      join
      drain();
      check("stall_cycles", stall_cnt, 4);

      // MAX_RUN=4 instance: five '+' saturate at 4, remainder flushed
      sel = 1'b1;
      expect_op(OP_CELL, 4, 1'b0, 8'h00);
      expect_op(OP_CELL, 1, 1'b0, 8'h00);
      repeat (5) put(CH_INC);
      do_flush();
      drain();
      sel = 1'b0;
      @(posedge clk); #1;

      // + - . : zero-net run
`ifdef BF_ZERO_DROP_EN
      expect_op(OP_PASS, 0, 1'b0, 8'h2E);
`else
      expect_op(OP_CELL, 0, 1'b0, 8'h00);
      expect_op(OP_PASS, 0, 1'b0, 8'h2E);
`endif
      put(CH_INC); put(CH_DEC); put(CH_OUT);
      drain();

      // reset while in EMIT_RUN
      op_ready = 1'b0;
      put(CH_INC);
      cmd_valid = 1'b1;
      cmd_data  = CH_RIGHT;
      wait_valid("emit_before_reset");
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("reset_op_valid", op_valid, 0);
      check("reset_op_mag",   op_mag, 0);
      check("reset_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b0;
      op_ready  = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // recovery after reset: pending run discarded, fresh run starts from zero
      expect_op(OP_CELL, 1, 1'b1, 8'h00);
      put(CH_DEC);
      do_flush();
      drain();

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
